// File: rtl/jitter_clock_ctrl_if.sv
// Configuration handshake bundle for the jittered clock controller.
// The master offers short/long/threshold values; the slave accepts them
// with cfg_ready when it is idle.
interface jitter_clock_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_short;
   logic [CNT_W-1:0] cfg_long;
   logic [3:0]       cfg_thresh;

   modport master (
      output cfg_valid,
      output cfg_short,
      output cfg_long,
      output cfg_thresh,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_short,
      input  cfg_long,
      input  cfg_thresh,
      output cfg_ready
   );
endinterface

// File: rtl/jitter_clock_ctrl.sv
// Jittered clock controller: divides CLK into gclk_out.
// Each half-period is either SHORT or LONG CLK cycles, picked at every
// reload from a free-running LFSR that steps once per gclk rising edge.
// Stopping always completes the high phase, so gclk_out never glitches.
module jitter_clock_ctrl #(
   parameter int                LFSR_W     = 32,
   parameter logic [LFSR_W-1:0] SEED       = 32'hACE12468,
   parameter int                CNT_W      = 8,
   parameter int                SHORT_DEF  = 1,
   parameter int                LONG_DEF   = 2,
   parameter int                THRESH_DEF = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ENABLE,
   jitter_clock_ctrl_if.slave cfg,
   output logic               gclk_out,
   output logic               rise,
   output logic               fall,
   output logic               busy,
   output logic [LFSR_W-1:0]  rand_val
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      STOP = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Left-shift LFSR step; the taps are fixed for a 32-bit register.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
   endfunction

   // A configured half-period of 0 behaves as 1 so the counter never wraps.
   function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b0}}) ? CNT_ONE : v;
   endfunction

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               gclk_r;
   logic               rise_r;
   logic               fall_r;
   logic               busy_r;
   logic               cfg_ready_r;
   logic [LFSR_W-1:0]  lfsr_r;
   logic [CNT_W-1:0]   short_r;
   logic [CNT_W-1:0]   long_r;
   logic [3:0]         thresh_r;

   logic [CNT_W-1:0]   half_s;
   logic [CNT_W-1:0]   reload_s;
   logic               toggle_s;
   logic               gclk_next_s;

   // Half-period chosen from the current (pre-step) LFSR value.
   assign half_s      = (lfsr_r[3:0] > thresh_r) ? at_least_one(short_r) : at_least_one(long_r);
   assign reload_s    = half_s - CNT_ONE;
   assign toggle_s    = (cnt_r == {CNT_W{1'b0}});
   assign gclk_next_s = gclk_r ^ toggle_s;

   // Sequencer, counter, LFSR and configuration registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         gclk_r      <= 1'b0;
         rise_r      <= 1'b0;
         fall_r      <= 1'b0;
         busy_r      <= 1'b0;
         cfg_ready_r <= 1'b1;
         lfsr_r      <= SEED;
         short_r     <= CNT_W'(SHORT_DEF);
         long_r      <= CNT_W'(LONG_DEF);
         thresh_r    <= 4'(THRESH_DEF);
      end else begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
         case (state_r)
            IDLE: begin
               gclk_r <= 1'b0;
               // Latch a new configuration; a start in the same cycle
               // still uses the old values because half_s reads the old registers.
               if (cfg.cfg_valid && cfg_ready_r) begin
                  short_r  <= cfg.cfg_short;
                  long_r   <= cfg.cfg_long;
                  thresh_r <= cfg.cfg_thresh;
               end else begin
                  short_r  <= short_r;
               end
               if (ENABLE) begin
                  state_r     <= RUN;
                  cnt_r       <= reload_s;
                  busy_r      <= 1'b1;
                  cfg_ready_r <= 1'b0;
               end else begin
                  cnt_r       <= {CNT_W{1'b0}};
                  busy_r      <= 1'b0;
                  cfg_ready_r <= 1'b1;
               end
            end
            RUN, STOP: begin
               if (toggle_s) begin
                  gclk_r <= ~gclk_r;
                  cnt_r  <= reload_s;
                  if (!gclk_r) begin
                     rise_r <= 1'b1;
                     lfsr_r <= lfsr_next(lfsr_r);
                  end else begin
                     fall_r <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
               // STOP only leaves on its falling toggle; RUN leaves when
               // ENABLE drops, via STOP if the clock is (or is becoming) high.
               if (state_r == STOP) begin
                  if (toggle_s) begin
                     state_r     <= IDLE;
                     busy_r      <= 1'b0;
                     cfg_ready_r <= 1'b1;
                  end else begin
                     state_r <= STOP;
                  end
               end else if (!ENABLE) begin
                  if (gclk_next_s) begin
                     state_r <= STOP;
                  end else begin
                     state_r     <= IDLE;
                     busy_r      <= 1'b0;
                     cfg_ready_r <= 1'b1;
                  end
               end else begin
                  state_r <= RUN;
               end
            end
            default: begin
               state_r     <= IDLE;
               gclk_r      <= 1'b0;
               cnt_r       <= {CNT_W{1'b0}};
               busy_r      <= 1'b0;
               cfg_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign cfg.cfg_ready = cfg_ready_r;
   assign gclk_out      = gclk_r;
   assign rise          = rise_r;
   assign fall          = fall_r;
   assign busy          = busy_r;
   assign rand_val      = lfsr_r;

endmodule
